// File: rtl/line_error_pkg.sv
// Shared types and sizing for the line-error path: FSM encoding, datapath widths
// and a constant clog2 used to size the pixel position counters.
package line_error_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int SUM_W      = 32;
  localparam int COUNT_W    = 32;
  localparam int DIV_CYCLES = 32;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/line_error_generator_seq_divider.sv
// Unsigned 32/32 restoring divider: one quotient bit per cycle, done pulses in the
// cycle whose closing edge commits the last bit, 32 edges after the start edge.
module seq_divider
  import line_error_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int CNT_W = clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [SUM_W-1:0] rem_q;
  logic [SUM_W-1:0] quo_q;
  logic [SUM_W-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [SUM_W:0]   rem_sh;
  logic             fits;
  logic [SUM_W:0]   rem_sub;

  // A 33-bit compare keeps the restore decision exact even for divisors near 2^32.
  always_comb begin
    rem_sh  = {rem_q, quo_q[SUM_W-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh - {1'b0, dvs_q};
  end

  assign done     = busy && (cnt_q == CNT_LAST);
  assign quotient = quo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start && !busy) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      rem_q <= fits ? rem_sub[SUM_W-1:0] : rem_sh[SUM_W-1:0];
      quo_q <= {quo_q[SUM_W-2:0], fits};
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/line_error_generator.sv
// Line centroid tracker: accumulates hit x-positions over the ROI of each frame,
// divides sum by count, and publishes centroid - IMG_WIDTH/2 once per frame.
module line_error_generator
  import line_error_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ROI_TOP    = 120,
  parameter int MIN_PIXELS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic               pix_sop,
  input  logic               pix_eop,
  input  logic               pix_hit,
  output logic signed [31:0] error,
  output logic               error_ready,
  output logic               line_lost,
  output logic               overrun
);

  localparam int X_W   = clog2(IMG_WIDTH);
  localparam int ROW_W = clog2(IMG_HEIGHT);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROI_ROW  = ROW_W'(ROI_TOP);

  logic [X_W-1:0]     x_q;
  logic [ROW_W-1:0]   row_q;
  logic [SUM_W-1:0]   sum_q;
  logic [COUNT_W-1:0] count_q;

  logic [X_W-1:0]     beat_x;
  logic [ROW_W-1:0]   beat_row;
  logic               beat_hit;
  logic [SUM_W-1:0]   sum_next;
  logic [COUNT_W-1:0] count_next;

  state_t             state;
  logic               lost_q;
  logic               eop_beat;
  logic               eop_go;
  logic               div_busy;
  logic               div_done;
  logic [SUM_W-1:0]   div_quo;

  // A sop beat sees itself at (0,0) with empty accumulators, so its own hit counts.
  always_comb begin
    beat_x     = pix_sop ? '0 : x_q;
    beat_row   = pix_sop ? '0 : row_q;
    beat_hit   = pix_hit && (beat_row >= ROI_ROW);
    sum_next   = (pix_sop ? '0 : sum_q) + (beat_hit ? SUM_W'(beat_x) : '0);
    count_next = (pix_sop ? '0 : count_q) + (beat_hit ? COUNT_W'(1) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      row_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else if (pix_valid) begin
      x_q     <= (beat_x == X_LAST) ? '0 : beat_x + X_W'(1);
      row_q   <= ((beat_x == X_LAST) && (beat_row != ROW_LAST)) ? beat_row + ROW_W'(1) : beat_row;
      sum_q   <= sum_next;
      count_q <= count_next;
    end
  end

  assign eop_beat = pix_valid && pix_eop;
  assign eop_go   = eop_beat && (state == ST_IDLE) && !div_busy;

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (eop_go),
    .dividend (sum_next),
    .divisor  (count_next),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Lost frames still run the divider so every result arrives at the same latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      lost_q      <= 1'b0;
      error       <= '0;
      error_ready <= 1'b0;
      line_lost   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      error_ready <= 1'b0;
      if (eop_beat && (state != ST_IDLE)) overrun <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (eop_go) begin
            lost_q <= (count_next < COUNT_W'(MIN_PIXELS));
            state  <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) state <= ST_OUT;
        end
        ST_OUT: begin
          error_ready <= 1'b1;
          line_lost   <= lost_q;
          if (!lost_q) error <= $signed(div_quo - 32'(IMG_WIDTH / 2));
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_error_generator.sv
// Bench for line_error_generator on a reduced 32x16 image: randomized frames are
// scored against a frame-level centroid model with pulse timing and overrun rules.
module tb_line_error_generator;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int ROI  = 8;
  localparam int MINP = 4;
  localparam int LAT  = 33;
  localparam int GAP  = 34;

  logic               clk = 1'b0;
  logic               rst;
  logic               pix_valid, pix_sop, pix_eop, pix_hit;
  logic signed [31:0] error;
  logic               error_ready, line_lost, overrun;

  line_error_generator #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ROI_TOP(ROI), .MIN_PIXELS(MINP)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eop(pix_eop), .pix_hit(pix_hit),
    .error(error), .error_ready(error_ready), .line_lost(line_lost), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int          exp_edge_q[$];
  logic [31:0] exp_err_q[$];
  logic        exp_lost_q[$];
  int          obs_edge_q[$];
  logic [31:0] obs_err_q[$];
  logic        obs_lost_q[$];

  int          spurious = 0;
  logic [31:0] prev_err = '0;
  logic        prev_lost = 1'b0;

  int          last_accept = -1000;
  int          model_err = 0;
  logic        exp_overrun = 1'b0;

  // Pulse log; error/line_lost moving without a pulse is tallied as spurious.
  always @(negedge clk) begin
    if (!rst) begin
      if (error_ready) begin
        obs_edge_q.push_back(cyc);
        obs_err_q.push_back(error);
        obs_lost_q.push_back(line_lost);
      end else if (error !== prev_err || line_lost !== prev_lost) begin
        spurious++;
      end
    end
    prev_err  = error;
    prev_lost = line_lost;
  end

  task automatic drive(input logic v, input logic s, input logic e, input logic h);
    @(negedge clk);
    pix_valid = v;
    pix_sop   = s;
    pix_eop   = e;
    pix_hit   = h;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    exp_edge_q.delete();
    exp_err_q.delete();
    exp_lost_q.delete();
    model_err   = 0;
    last_accept = -1000;
    exp_overrun = 1'b0;
  endtask

  // Frame-level reference: centroid of ROI hits, acceptance by eop spacing.
  task automatic model_frame(input int eop_edge, input int sum, input int cnt);
    if (eop_edge - last_accept >= GAP) begin
      last_accept = eop_edge;
      if (cnt < MINP) begin
        exp_lost_q.push_back(1'b1);
      end else begin
        model_err = sum / cnt - W / 2;
        exp_lost_q.push_back(1'b0);
      end
      exp_edge_q.push_back(eop_edge + LAT);
      exp_err_q.push_back(32'(model_err));
    end else begin
      exp_overrun = 1'b1;
    end
  endtask

  // mode 0: column arg; 1: columns 0 and 3; 2: rows above ROI only; else arg% random
  task automatic send_frame(input int nbeats, input int mode, input int arg,
                            input int gap_pct, input bit with_eop);
    int sum, cnt, x, row;
    bit hit;
    sum = 0;
    cnt = 0;
    for (int i = 0; i < nbeats; i++) begin
      x   = i % W;
      row = i / W;
      if (row > H - 1) row = H - 1;
      case (mode)
        0:       hit = (x == arg);
        1:       hit = (x == 0) || (x == 3);
        2:       hit = (row < ROI) && ($urandom_range(0, 1) == 1);
        default: hit = ($urandom_range(0, 99) < arg);
      endcase
      if (hit && row >= ROI) begin
        sum += x;
        cnt++;
      end
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      if (i == nbeats - 1 && with_eop) begin
        drive(1'b1, i == 0, 1'b1, hit);
        model_frame(cyc + 1, sum, cnt);
      end else begin
        drive(1'b1, i == 0, 1'b0, hit);
      end
    end
  endtask

  task automatic check_results(input string tag);
    int e, oe;
    logic [31:0] eerr, oerr;
    logic elost, olost;
    while (exp_edge_q.size() > 0) begin
      e     = exp_edge_q.pop_front();
      eerr  = exp_err_q.pop_front();
      elost = exp_lost_q.pop_front();
      vectors++;
      if (obs_edge_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s missing_pulse: got 0 pulses, expected one at edge %0d", tag, e);
      end else begin
        oe    = obs_edge_q.pop_front();
        oerr  = obs_err_q.pop_front();
        olost = obs_lost_q.pop_front();
        if (oe !== e) begin
          miscompares++;
          $display("FAIL %s pulse_edge: got %0d, expected %0d", tag, oe, e);
        end
        vectors++;
        if (oerr !== eerr) begin
          miscompares++;
          $display("FAIL %s error: got %0d, expected %0d", tag, $signed(oerr), $signed(eerr));
        end
        vectors++;
        if (olost !== elost) begin
          miscompares++;
          $display("FAIL %s line_lost: got %0b, expected %0b", tag, olost, elost);
        end
      end
    end
    vectors++;
    if (obs_edge_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s extra_pulse: got %0d unexpected pulses, expected 0", tag, obs_edge_q.size());
    end
    obs_edge_q.delete();
    obs_err_q.delete();
    obs_lost_q.delete();
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("FAIL %s output_change: got %0d changes without pulse, expected 0", tag, spurious);
    end
    spurious = 0;
    vectors++;
    if (overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL %s overrun: got %0b, expected %0b", tag, overrun, exp_overrun);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (error !== 32'sd0 || error_ready !== 1'b0 || line_lost !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL %s reset_outputs: got err=%0d rdy=%0b lost=%0b ovr=%0b, expected all 0",
               tag, error, error_ready, line_lost, overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      check_reset_outputs("reset");
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    idle(3);
  endtask

  task automatic test_centred_right();
    send_frame(W * H, 0, 20, 0, 1'b1);
    idle(40);
    check_results("centred_right");
  endtask

  task automatic test_floor();
    send_frame(W * H, 1, 0, 0, 1'b1);
    idle(40);
    check_results("floor");
  endtask

  task automatic test_lost();
    send_frame(W * H, 2, 0, 10, 1'b1);
    idle(40);
    check_results("lost");
  endtask

  task automatic test_one_pixel();
    send_frame(1, 3, 100, 0, 1'b1);
    idle(40);
    check_results("one_pixel");
  endtask

  task automatic test_random();
    send_frame($urandom_range(50, 400), 3, 30, 10, 1'b0);
    for (int f = 0; f < 5; f++) begin
      send_frame(W * H, 3, $urandom_range(0, 20), 15, 1'b1);
      idle(40);
    end
    check_results("random");
  endtask

  task automatic test_back_to_back();
    send_frame(W * H, 3, 10, 0, 1'b1);
    send_frame(GAP, 3, 50, 0, 1'b1);
    idle(75);
    check_results("back_to_back");
  endtask

  task automatic test_overrun();
    send_frame(W * H, 0, 5, 0, 1'b1);
    send_frame(10, 3, 50, 0, 1'b1);
    idle(45);
    check_results("overrun_10");
    send_frame(W * H, 3, 12, 5, 1'b1);
    send_frame(GAP - 1, 3, 50, 0, 1'b1);
    idle(75);
    check_results("overrun_33");
  endtask

  task automatic test_reset_mid_divide();
    int e;
    send_frame(W * H, 3, 15, 0, 1'b1);
    e = last_accept;
    for (int k = 0; k < 100 && cyc < e + 14; k++) idle(1);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_reset_outputs("reset_mid_divide");
    end
    rst = 1'b0;
    idle(45);
    check_results("reset_mid_divide");
    send_frame(W * H, 0, W / 2, 0, 1'b1);
    idle(40);
    check_results("after_reset");
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sop   = 1'b0;
    pix_eop   = 1'b0;
    pix_hit   = 1'b0;
    test_reset();
    test_centred_right();
    test_floor();
    test_lost();
    test_one_pixel();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid_divide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_error_generator.md
# line_error_generator

Computes the lateral tracking error that feeds the PID controller's `error`/`error_ready` inputs. It consumes a binarised camera pixel stream (one hit bit per pixel), accumulates the x-coordinate sum and hit count over a region of interest per frame, and divides them with a sequential divider to get the line centroid. It then emits `centroid - IMG_WIDTH/2` as a signed 32-bit error with a one-cycle `error_ready` pulse per frame.

## Interface
Parameters:
- `IMG_WIDTH`, 320: pixels per row; even, at most 4096.
- `IMG_HEIGHT`, 240: rows per frame.
- `ROI_TOP`, 120: first row counted; rows `ROI_TOP..IMG_HEIGHT-1` contribute.
- `MIN_PIXELS`, 4: minimum hit count for a valid frame.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pix_valid`  in  1  pixel beat valid; no backpressure, every valid beat is accepted.
- `pix_sop`  in  1  first pixel of frame; qualified by `pix_valid`.
- `pix_eop`  in  1  last pixel of frame; qualified by `pix_valid`.
- `pix_hit`  in  1  pixel classified as line.
- `error`  out  32 signed  `centroid_x - IMG_WIDTH/2`; positive means the line is right of centre.
- `error_ready`  out  1  one-cycle pulse per completed frame.
- `line_lost`  out  1  last frame had fewer than `MIN_PIXELS` hits; valid with `error_ready`, held until the next pulse.
- `overrun`  out  1  sticky; set when a frame is dropped, cleared only by `rst`.

## Operation
Position counters:
- `x` increments on each valid beat and wraps from `IMG_WIDTH-1` to 0.
- `row` increments on each `x` wrap and saturates at `IMG_HEIGHT-1`.
- A valid `pix_sop` beat forces `x=0` and `row=0` for that beat.

Accumulation:
- A valid beat with `pix_hit=1` and `row>=ROI_TOP` adds `x` to `sum` (32 bit) and 1 to `count` (32 bit).
- A `pix_sop` beat loads `sum`/`count` with that beat's own contribution. This replaces any prior values, so a frame missing its eop is discarded silently.
- `sop` and `eop` on the same beat form a legal one-pixel frame.

FSM states: IDLE, DIV, OUT.
- IDLE plus valid eop beat:
  - Latch the final `sum`/`count`, including the eop beat's contribution, into divider operands.
  - Set `lost = (count_final < MIN_PIXELS)`.
  - Start the divider and go to DIV.
- DIV: the divider runs 32 iterations, one quotient bit per cycle. Leave after the 32nd iteration and go to OUT.
- OUT, valid frame: `error <= quotient - IMG_WIDTH/2`, sign-extended, and `line_lost <= 0`.
- OUT, lost frame: `error` holds its previous value, `line_lost <= 1`, and the quotient is ignored.
- OUT: `error_ready` is 1 for this cycle only, then go to IDLE.
- A lost frame still traverses DIV, so latency is uniform. Division by zero is harmless because the result is discarded.
- Divider arithmetic: unsigned restoring division, 32/32. The quotient is truncated (floor) and always lies in `0..IMG_WIDTH-1`.
- Accumulation runs continuously in every state. The next frame's pixels are counted while DIV is busy.
- Valid eop beat while not in IDLE:
  - That frame's result is dropped and `overrun <= 1`.
  - The in-flight result completes normally.
  - Accumulators are still cleared by the next sop.

## Timing
- Reset values: `error=0`, `error_ready=0`, `line_lost=0`, `overrun=0`, FSM in IDLE, `x`/`row`/`sum`/`count`=0.
- Latency: eop beat sampled at edge 0. DIV occupies edges 1–32. `error`, `line_lost` and `error_ready` update at edge 33, and `error_ready` is high from edge 33 to edge 34.
- Throughput: one result per 34 cycles. An eop arriving at edge ≥34 after the previous eop is always accepted.
- `error` and `line_lost` change only at the `error_ready` edge.
- `rst` mid-frame or mid-divide aborts immediately: no pulse is issued and all outputs return to reset values.
- `pix_sop`, `pix_eop` and `pix_hit` are ignored when `pix_valid=0`.

## Structure
- `line_error_pkg`:
  - FSM state enum (IDLE/DIV/OUT).
  - `SUM_W=32`, `COUNT_W=32`, `DIV_CYCLES=32`.
  - Function `clog2` for sizing the `x`/`row` counters.
- Sub-module `seq_divider`:
  - Unsigned 32/32 restoring divider with a `start` pulse, a `busy` flag and a one-cycle `done` pulse.
  - Exactly 32 cycles from `start` to `done`.
  - Async active-high reset.
- Top level: position counters, accumulators, FSM and output registers.

## Test plan
- Reset: assert `rst` with random pixel inputs → `error=0`, `error_ready=0`, `line_lost=0`, `overrun=0`, held throughout reset.
- Centred-right line: 320×240 frame, hit only at x=200 on every row; rows <120 carry hits that must be ignored → count 120, sum 24000, `error=+40`, `line_lost=0`, single pulse exactly 33 edges after the eop edge.
- Floor rounding: hits at x=0 and x=3 on rows 120–239 → quotient 1 (1.5 truncated) → `error=-159`.
- Lost line: after the previous test, send a frame with hits only in rows 0–119 → `line_lost=1`, `error` stays −159, pulse still at edge 33.
- Overrun: a second 10-pixel frame whose eop lands 10 cycles after the first eop → exactly one pulse carrying the first frame's result, `overrun=1` and sticky.
- Reset mid-divide: assert `rst` at edge 15 after eop → no pulse, outputs at reset values; the next full frame with hit at x=160 gives `error=0` at the normal latency.
